// File: rtl/mux_rr_arb.sv
// Registered N:1 channel mux with valid/ready handshakes: fixed select (MODE=0) or
// round-robin arbitration (MODE=1) feeding a single output register.
module mux_rr_arb #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CH    = 4,
  parameter int unsigned MODE  = 1,
  localparam int unsigned SW   = $clog2(CH)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CH*WIDTH-1:0] in_data_i,
  input  logic [CH-1:0]       in_valid_i,
  output logic [CH-1:0]       in_ready_o,
  input  logic [SW-1:0]       sel_i,
  output logic [WIDTH-1:0]    out_data_o,
  output logic [SW-1:0]       out_ch_o,
  output logic                out_valid_o,
  input  logic                out_ready_i
);

  logic [SW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SW-1:0]    ch_q, ch_d;
  logic             valid_q, valid_d;

  logic             load_en;
  logic [SW-1:0]    grant;
  logic             grant_vld;
  logic [SW-1:0]    idx;
  logic [CH-1:0]    ready;
  logic             xfer;

  assign load_en = ~valid_q | out_ready_i;

  // Scan offsets from CH down to 1 so the smallest offset past ptr wins;
  // offset CH wraps to ptr itself, the lowest priority.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = '0;
    if (MODE == 0) begin
      grant     = sel_i;
      grant_vld = 1'b1;
    end else begin
      for (int k = int'(CH); k >= 1; k--) begin
        idx = ptr_q + SW'(k);
        if (in_valid_i[idx]) begin
          grant     = idx;
          grant_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ready = '0;
    if (grant_vld && load_en && !rst_i) begin
      ready[grant] = 1'b1;
    end
  end

  assign xfer = |(ready & in_valid_i);

  always_comb begin
    ptr_d   = ptr_q;
    data_d  = data_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    if (load_en) begin
      valid_d = xfer;
      if (xfer) begin
        data_d = in_data_i[grant*WIDTH +: WIDTH];
        ch_d   = grant;
        if (MODE != 0) begin
          ptr_d = grant;
        end
      end
    end
  end

  // ptr resets to CH-1 so channel 0 is searched first.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q   <= SW'(CH - 1);
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
    end
  end

  assign in_ready_o  = ready;
  assign out_data_o  = data_q;
  assign out_ch_o    = ch_q;
  assign out_valid_o = valid_q;

endmodule

// File: tb/tb_mux_rr_arb.sv
// Bench for mux_rr_arb: a round-robin instance and a fixed-select instance driven side by side
// and compared against a behavioural model of the arbitration and output register.
module tb_mux_rr_arb;
  localparam int W  = 4;
  localparam int CH = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [CH*W-1:0] in_data, in_data0;
  logic [CH-1:0]   in_valid, in_valid0, in_ready, in_ready0;
  logic [SW-1:0]   sel, sel0, out_ch, out_ch0;
  logic [W-1:0]    out_data, out_data0;
  logic            out_valid, out_valid0, out_ready, out_ready0;

  mux_rr_arb #(.WIDTH(W), .CH(CH), .MODE(1)) u_rr (
    .clk_i(clk), .rst_i(rst), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .sel_i(sel), .out_data_o(out_data), .out_ch_o(out_ch),
    .out_valid_o(out_valid), .out_ready_i(out_ready)
  );

  mux_rr_arb #(.WIDTH(W), .CH(CH), .MODE(0)) u_fix (
    .clk_i(clk), .rst_i(rst), .in_data_i(in_data0), .in_valid_i(in_valid0),
    .in_ready_o(in_ready0), .sel_i(sel0), .out_data_o(out_data0), .out_ch_o(out_ch0),
    .out_valid_o(out_valid0), .out_ready_i(out_ready0)
  );

  int errors = 0;
  int checks = 0;

  // Round-robin model state
  int m_valid, m_data, m_ch, m_ptr;
  // Fixed-select model state
  int f_valid, f_data, f_ch;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lowest requesting channel above ptr, else lowest requesting channel overall.
  function automatic int rr_pick(input logic [CH-1:0] v, input int ptr);
    for (int c = ptr + 1; c < CH; c++) if (v[c]) return c;
    for (int c = 0; c <= ptr; c++) if (v[c]) return c;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_ch = 0; m_ptr = CH - 1;
    f_valid = 0; f_data = 0; f_ch = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ":rr_valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, ":rr_data"}, 32'(out_data), 32'(m_data));
    check({tag, ":rr_ch"}, 32'(out_ch), 32'(m_ch));
    check({tag, ":fx_valid"}, 32'(out_valid0), 32'(f_valid));
    check({tag, ":fx_data"}, 32'(out_data0), 32'(f_data));
    check({tag, ":fx_ch"}, 32'(out_ch0), 32'(f_ch));
  endtask

  // Inputs are already driven; check handshakes, advance one edge, check outputs.
  task automatic cycle(input string tag);
    bit load, fload;
    int g, fs;
    logic [CH-1:0] exp_rdy, exp_rdy0;
    #1;
    load  = (m_valid == 0) || out_ready;
    g     = rr_pick(in_valid, m_ptr);
    exp_rdy = (load && g >= 0) ? CH'(1 << g) : '0;
    fload = (f_valid == 0) || out_ready0;
    fs    = int'(sel0);
    exp_rdy0 = fload ? CH'(1 << fs) : '0;
    check({tag, ":rr_ready"}, 32'(in_ready), 32'(exp_rdy));
    check({tag, ":fx_ready"}, 32'(in_ready0), 32'(exp_rdy0));
    @(posedge clk);
    if (load) begin
      if (g >= 0) begin
        m_valid = 1; m_data = int'(in_data[g*W +: W]); m_ch = g; m_ptr = g;
      end else begin
        m_valid = 0;
      end
    end
    if (fload) begin
      if (in_valid0[fs]) begin
        f_valid = 1; f_data = int'(in_data0[fs*W +: W]); f_ch = fs;
      end else begin
        f_valid = 0;
      end
    end
    #1;
    check_outputs(tag);
  endtask

  // Asserted between edges: outputs must clear before any clock edge arrives.
  task automatic apply_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs({tag, ":async"});
    check({tag, ":rr_ready"}, 32'(in_ready), 32'h0);
    check({tag, ":fx_ready"}, 32'(in_ready0), 32'h0);
    @(posedge clk);
    #1;
    check_outputs({tag, ":held"});
    check({tag, ":rr_ready_held"}, 32'(in_ready), 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    in_data = '0; in_valid = '1; sel = '0; out_ready = 1'b1;
    in_data0 = '0; in_valid0 = '0; sel0 = '0; out_ready0 = 1'b1;
    model_reset();
    apply_reset("por");

    // Round-robin with all channels requesting: 0,1,2,3,0,...
    in_valid = '1;
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < CH; c++) in_data[c*W +: W] = W'(c + 4 * (k % 3));
      cycle("rr_all");
      check("rr_all_seq", 32'(out_ch), 32'(k % CH));
      check("rr_all_valid", 32'(out_valid), 32'h1);
    end

    // Mid-stream reset, then channel 0 wins first.
    apply_reset("mid");
    in_valid = '1;
    cycle("after_rst");
    check("after_rst_ch0", 32'(out_ch), 32'h0);

    // Only channels 0 and 2 requesting: 0, 2, 0, 2 from reset.
    apply_reset("sparse_rst");
    in_valid = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      in_data = $urandom;
      cycle("sparse");
      check("sparse_seq", 32'(out_ch), 32'((k % 2) * 2));
    end

    // No requests: output drains, pointer stays at 2 so channel 3 is next.
    in_valid = '0;
    cycle("idle");
    check("idle_valid", 32'(out_valid), 32'h0);
    in_valid = '1;
    cycle("idle_resume");
    check("resume_ch3", 32'(out_ch), 32'h3);

    // Stall with new data pending on the granted channel.
    in_valid = 4'b0010;
    in_data[1*W +: W] = 4'b0011;
    cycle("pre_stall");
    out_ready = 1'b0;
    in_data[1*W +: W] = 4'b1100;
    for (int k = 0; k < 3; k++) begin
      cycle("stall");
      check("stall_data", 32'(out_data), 32'h3);
    end
    out_ready = 1'b1;
    cycle("release");
    check("release_data", 32'(out_data), 32'hc);

    // Fixed select stepping through one-hot channel data.
    in_valid = '0;
    in_data0 = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
    in_valid0 = '1;
    for (int k = 0; k < 4; k++) begin
      sel0 = SW'(k);
      cycle("fix_step");
      check("fix_step_data", 32'(out_data0), 32'(1 << k));
      check("fix_step_ch", 32'(out_ch0), 32'(k));
    end

    // Random traffic on both instances.
    for (int k = 0; k < 400; k++) begin
      in_data    = CH*W'($urandom);
      in_valid   = CH'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      sel        = SW'($urandom);
      in_data0   = CH*W'($urandom);
      in_valid0  = CH'($urandom);
      out_ready0 = ($urandom_range(0, 3) != 0);
      sel0       = SW'($urandom);
      cycle("rand");
      if (k == 200) apply_reset("rand_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mux_rr_arb.md
MUX_RR_ARB -- requirements
Module: mux_rr_arb

Interface
REQ-001 Parameter WIDTH, default 4, data bits per channel.
REQ-002 Parameter CH, default 4, number of input channels; power of 2, 2..16.
REQ-003 Parameter MODE, default 1: 0 = fixed select from sel; 1 = round-robin arbitration.
REQ-004 Derived SW = log2(CH), width of select/channel fields.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-007 in_data  input  CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 in_valid  input  CH  per-channel request.
REQ-009 in_ready  output  CH  per-channel accept; a beat transfers when in_valid[i] & in_ready[i].
REQ-010 sel  input  SW  channel select, used only when MODE=0.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_ch  output  SW  channel index that supplied out_data.
REQ-013 out_valid  output  1  out_data/out_ch hold a beat.
REQ-014 out_ready  input  1  downstream accept; output beat retires when out_valid & out_ready.

Function
REQ-015 Single output register; load_en = ~out_valid | out_ready.
REQ-016 Grant computed combinationally each cycle; at most one in_ready bit high, and only when load_en=1.
REQ-017 MODE=0: grant = sel; in_ready[sel] = load_en; other channels' in_valid ignored.
REQ-018 MODE=1: grant = first channel with in_valid set, searching from (ptr+1) mod CH upward with wrap-around; no grant if no in_valid.
REQ-019 MODE=1: ptr updates to the granted index only on an accepted transfer; otherwise ptr holds.
REQ-020 On accepted transfer: out_data <= granted channel data, out_ch <= grant, out_valid <= 1 on next edge; latency 1 cycle input-to-output.
REQ-021 If load_en=1 and no transfer, out_valid <= 0 next edge; out_data/out_ch hold last values.
REQ-022 If out_valid=1 and out_ready=0 (stall): out_data, out_ch, out_valid hold; all in_ready=0; ptr holds.
REQ-023 Simultaneous retire and load (out_valid & out_ready & transfer): new beat replaces old in same edge, out_valid stays 1; full throughput of 1 beat/cycle.
REQ-024 Input data is sampled only at the transfer edge; changes on in_data while not granted have no effect.
REQ-025 in_valid may drop without transfer; arbiter treats it as a fresh request set each cycle.
REQ-026 Round-robin fairness: with all CH channels continuously valid and out_ready=1, each channel granted exactly once per CH consecutive cycles.

Reset
REQ-027 While reset=1: out_valid=0, out_data=0, out_ch=0, in_ready=0, ptr=CH-1 (channel 0 highest priority after reset).
REQ-028 Reset asserted mid-operation discards any held beat asynchronously; no transfer is counted on the edge at which reset is high.
REQ-029 First grant possible on the first rising edge after reset deasserts.

Verification
REQ-030 MODE=0, WIDTH=4, CH=4, in_data = {1000,0100,0010,0001}, all valid, out_ready=1, sel stepping 0,1,2,3 every cycle -> out_data 0001,0010,0100,1000 one cycle after each sel, out_ch matches.
REQ-031 MODE=1, all 4 valid, out_ready=1 continuously after reset -> out_ch sequence 0,1,2,3,0,1... with out_valid=1 every cycle from cycle 1.
REQ-032 MODE=1, only in_valid[2] and in_valid[0] high, ptr=0 -> grant 2, then 0, then 2; in_ready[1], in_ready[3] never high.
REQ-033 Stall: out_valid=1, out_ready=0 for 3 cycles with new data 1100 on granted channel -> out_data unchanged, in_ready=0, ptr unchanged; on release, 1100 loads next edge.
REQ-034 Reset pulse while out_valid=1 -> out_valid, out_data, out_ch go 0 without waiting for clk; after release, channel 0 granted first if valid.
REQ-035 No in_valid with out_ready=1 -> out_valid falls to 0 next edge, ptr and out_data hold.
